// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock FWFT FIFO.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; flags decode from the registered occupancy count only.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH_LG2    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRES  = 1,
    parameter int AEMPTY_THRES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full,
    output logic                  afull,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  empty,
    output logic                  aempty,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam int PW    = DEPTH_LG2 + 1;
    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRES);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRES);
    localparam logic [PW-1:0] ONE_C    = PW'(1);

    if (DEPTH_LG2 < 1) begin : g_bad_depth
        $error("sync_fifo: DEPTH_LG2 must be >= 1");
    end
    if (AFULL_THRES <= 0 || AFULL_THRES >= DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_THRES out of range");
    end
    if (AEMPTY_THRES <= 0 || AEMPTY_THRES >= DEPTH) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THRES out of range");
    end

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         cnt;
    logic                  push_acc;
    logic                  pop_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;
    fifo_flags_t           flags;

    always_comb begin
        flags        = '0;
        flags.full   = (cnt == DEPTH_C);
        flags.empty  = (cnt == '0);
        flags.afull  = ((DEPTH_C - cnt) <= AFULL_C);
        flags.aempty = (cnt <= AEMPTY_C);
    end

    assign full   = flags.full;
    assign afull  = flags.afull;
    assign empty  = flags.empty;
    assign aempty = flags.aempty;

    // Acceptance uses the pre-edge flags, so full&wren&rden pops only and empty&wren&rden pushes only.
    assign push_acc = wren && !flags.full;
    assign pop_acc  = rden && !flags.empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + ONE_C;
            end
            if (pop_acc) begin
                rptr <= rptr + ONE_C;
            end
            cnt <= cnt + PW'(push_acc) - PW'(pop_acc);
        end
    end

    sync_fifo_mem #(
        .ADDR_WIDTH(DEPTH_LG2),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (push_acc && !rst),
        .waddr(wptr[DEPTH_LG2-1:0]),
        .wdata(wdata),
        .raddr(rptr[DEPTH_LG2-1:0]),
        .rdata(mem_rdata)
    );

    assign rdata = flags.empty ? '0 : mem_rdata;

    // Illegal requests are reported in simulation only; the wrap bits let the count be cross-checked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wren && flags.full))
                else $warning("sync_fifo: push while full dropped");
            assert (!(rden && flags.empty))
                else $warning("sync_fifo: pop while empty ignored");
            assert (cnt == (wptr - rptr))
                else $error("sync_fifo: count and pointers disagree");
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=4, 8-bit data): vector table plus queue-based data scoreboard.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          full;
    logic          afull;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          empty;
    logic          aempty;
    logic          rden;
    logic [DW-1:0] rdata;

    int tests_run;
    int tests_failed;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          r;
        logic          w;
        logic [DW-1:0] d;
        logic          rd;
        logic          e;
        logic          ae;
        logic          f;
        logic          af;
        logic [DW-1:0] q;
    } vec_t;

    vec_t vecs[9];

    sync_fifo #(
        .DEPTH_LG2   (2),
        .DATA_WIDTH  (DW),
        .AFULL_THRES (1),
        .AEMPTY_THRES(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .full  (full),
        .afull (afull),
        .wren  (wren),
        .wdata (wdata),
        .empty (empty),
        .aempty(aempty),
        .rden  (rden),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
        end
    endtask

    // Compare every output against the bench's own queue model; called away from the rising edge.
    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        check({tag, " empty"},  {7'd0, empty},  {7'd0, n == 0});
        check({tag, " full"},   {7'd0, full},   {7'd0, n == DEPTH});
        check({tag, " afull"},  {7'd0, afull},  {7'd0, (DEPTH - n) <= 1});
        check({tag, " aempty"}, {7'd0, aempty}, {7'd0, n <= 1});
        check({tag, " rdata"},  rdata, (n > 0) ? exp_q[0] : 8'h00);
    endtask

    // Drive one cycle from the falling edge, update the model at the rising edge, sample at the next falling edge.
    task automatic cycle(input logic r, input logic w, input logic [DW-1:0] d, input logic rd, input string tag);
        bit push_ok;
        bit pop_ok;
        rst   = r;
        wren  = w;
        wdata = d;
        rden  = rd;
        push_ok = w && (exp_q.size() < DEPTH);
        pop_ok  = rd && (exp_q.size() > 0);
        if (pop_ok && !r) begin
            check({tag, " pop data"}, rdata, exp_q[0]);
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            if (pop_ok)  void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back(d);
        end
        @(negedge clk);
        rst  = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
        check_model(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        wren  = 1'b0;
        rden  = 1'b0;
        wdata = '0;

        // 1: reset held two cycles
        @(negedge clk);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, "reset0");
        cycle(1'b1, 1'b0, 8'h00, 1'b0, "reset1");
        check("reset empty",  {7'd0, empty},  8'h01);
        check("reset aempty", {7'd0, aempty}, 8'h01);
        check("reset full",   {7'd0, full},   8'h00);
        check("reset afull",  {7'd0, afull},  8'h00);
        check("reset rdata",  rdata,          8'h00);

        // 2: fill, overflow attempt, drain; expected flags hand-derived per step
        vecs[0] = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0};
        vecs[1] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0};
        vecs[2] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0};
        vecs[3] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].rd, $sformatf("fill%0d", i));
            check($sformatf("vec%0d empty", i),  {7'd0, empty},  {7'd0, vecs[i].e});
            check($sformatf("vec%0d aempty", i), {7'd0, aempty}, {7'd0, vecs[i].ae});
            check($sformatf("vec%0d full", i),   {7'd0, full},   {7'd0, vecs[i].f});
            check($sformatf("vec%0d afull", i),  {7'd0, afull},  {7'd0, vecs[i].af});
            check($sformatf("vec%0d rdata", i),  rdata,          vecs[i].q);
        end

        // 3: steady state with two entries resident
        cycle(1'b0, 1'b1, 8'h30, 1'b0, "pre0");
        cycle(1'b0, 1'b1, 8'h31, 1'b0, "pre1");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b1, $sformatf("steady%0d", i));
            check("steady aempty", {7'd0, aempty}, 8'h00);
            check("steady afull",  {7'd0, afull},  8'h00);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "sdrain0");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "sdrain1");
        check("steady drained", {7'd0, empty}, 8'h01);

        // 4: wrap the pointers with random gaps, never reaching full
        for (int v = 1; v <= 9; ) begin
            logic w;
            logic rd;
            w  = ($urandom_range(0, 2) != 0) && (exp_q.size() < DEPTH - 1);
            rd = ($urandom_range(0, 1) != 0) && (exp_q.size() > 0);
            cycle(1'b0, w, 8'(v), rd, "wrap");
            if (w) v++;
        end
        while (exp_q.size() > 0) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, "wdrain");
        end

        // 5: empty corners
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "pop empty");
        check("pop empty stays empty", {7'd0, empty}, 8'h01);
        cycle(1'b0, 1'b1, 8'h3C, 1'b1, "both on empty");
        check("both on empty rdata", rdata, 8'h3C);
        check("both on empty aempty", {7'd0, aempty}, 8'h01);
        check("both on empty not empty", {7'd0, empty}, 8'h00);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, "drain5");

        // 6: reset mid-run discards contents and ignores the concurrent push
        cycle(1'b0, 1'b1, 8'h71, 1'b0, "mid0");
        cycle(1'b0, 1'b1, 8'h72, 1'b0, "mid1");
        cycle(1'b0, 1'b1, 8'h73, 1'b0, "mid2");
        cycle(1'b1, 1'b1, 8'h74, 1'b0, "mid rst");
        check("mid rst empty", {7'd0, empty}, 8'h01);
        check("mid rst full",  {7'd0, full},  8'h00);
        check("mid rst rdata", rdata,         8'h00);
        cycle(1'b0, 1'b1, 8'h55, 1'b0, "post rst push");
        check("post rst rdata", rdata, 8'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
